// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg - shared IF/ID widths, NOP encoding and payload type
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned CPU_PC_W   = 6;
  localparam int unsigned CPU_INST_W = 16;

  localparam logic [CPU_INST_W-1:0] CPU_NOP_INST = 16'h0000;

  typedef struct packed {
    logic [CPU_PC_W-1:0]   pc;
    logic [CPU_INST_W-1:0] inst;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_slot - one valid+payload register with load/clear (clear wins)
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_slot
  import cpu_pkg::*;
#(
  parameter int unsigned W = CPU_PC_W + CPU_INST_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clearing only drops the valid bit; the payload is kept so the
  // downstream PC field holds its last value while the slot is empty.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_id_stage - IF/ID pipeline register with valid/ready, skid slot and flush
// Rev 1.0
// ----------------------------------------------------------------------------
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       PC_W     = CPU_PC_W,
  parameter int unsigned       INST_W   = CPU_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(CPU_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pcadd4,
  input  logic [INST_W-1:0] inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   newpc,
  output logic [INST_W-1:0] instout,
  output logic [1:0]        occ
);

  localparam int unsigned SLOT_W = PC_W + INST_W;

  logic              main_valid, skid_valid;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [SLOT_W-1:0] main_d, main_q, skid_q;
  logic              accept, pop;

  // in_ready comes straight from the skid flop, so it never depends on out_ready.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = {pcadd4, inst};
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid) begin
      main_load = accept;
    end else if (pop) begin
      if (skid_valid) begin
        main_load  = 1'b1;
        main_d     = skid_q;
        skid_clear = 1'b1;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else begin
      skid_load = accept;
    end
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .d     ({pcadd4, inst}),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign out_valid = main_valid;
  assign newpc     = main_q[SLOT_W-1:INST_W];
  assign instout   = main_valid ? main_q[INST_W-1:0] : NOP_INST;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
`default_nettype wire
